// File: rtl/cips_pkg.sv
// Shared CIPS datapath types and width constants.
package cips_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 11;

  typedef struct packed {
    logic [2:0] ctrl;
    logic [3:0] x;
    logic [3:0] y;
  } instr_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    instr_t            instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// Circular buffer with registered head entry that holds its last value when empty.
module fq_ring #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, remain_c;
  logic [W-1:0]     rd_q, rd_d;
  logic             valid_q, valid_d;

  // Head register is preloaded with the entry that will sit at the head after this edge.
  always_comb begin
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    rd_d     = rd_q;
    remain_c = count_q - CNT_W'(pop);
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = wr_data;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (remain_c != '0) rd_d = mem_q[head_d];
      else if (push)      rd_d = wr_data;
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data  = rd_q;
  assign rd_valid = valid_q;
  assign count    = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC, instruction memory drive and fetch queue toward decode.
// Optional FETCH_QUEUE_STATS_EN adds saturating fetch/stall counters.
module instr_fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = cips_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cips_pkg::INSTR_W
) (
  input  logic                   clk,
  input  logic                   R,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [INSTR_W-1:0]     mem_data,
  input  logic                   halt,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]            stat_fetched,
  output logic [15:0]            stat_stalls
`endif
);

  import cips_pkg::*;

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               push_c, pop_c, valid_c;
  logic [CNT_W-1:0]   count_c;
  logic [ENTRY_W-1:0] head_c;

  assign pop_c  = valid_c & out_ready;
  assign push_c = !halt && !flush && ((count_c < CNT_W'(DEPTH)) || pop_c);

  always_comb begin
    pc_d = pc_q;
    if (flush)       pc_d = flush_pc;
    else if (push_c) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) pc_q <= '0;
    else   pc_q <= pc_d;
  end

  fq_ring #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ring (
    .clk      (clk),
    .rst      (R),
    .push     (push_c),
    .pop      (pop_c),
    .clear    (flush),
    .wr_data  ({pc_q, mem_data}),
    .rd_data  (head_c),
    .rd_valid (valid_c),
    .count    (count_c)
  );

  assign mem_addr            = pc_q;
  assign out_valid           = valid_c;
  assign count               = count_c;
  assign {out_pc, out_instr} = head_c;

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stat_fetched_q, stat_fetched_d, stat_stalls_q, stat_stalls_d;

  // Counters saturate; flush leaves them untouched.
  always_comb begin
    stat_fetched_d = stat_fetched_q;
    stat_stalls_d  = stat_stalls_q;
    if (push_c && stat_fetched_q != 16'hFFFF) stat_fetched_d = stat_fetched_q + 16'd1;
    if (valid_c && !out_ready && stat_stalls_q != 16'hFFFF) stat_stalls_d = stat_stalls_q + 16'd1;
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      stat_fetched_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_stalls_q  <= stat_stalls_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;

  logic        clk;
  logic        R;
  logic        halt, flush, out_ready;
  logic [7:0]  flush_pc, mem_addr, out_pc;
  logic [10:0] mem_data, out_instr;
  logic        out_valid;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stat_fetched, stat_stalls;
`endif

  logic [10:0] mem [256];
  assign mem_data = mem[mem_addr];

  instr_fetch_queue dut (
    .clk       (clk),
    .R         (R),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .halt      (halt),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_stalls  (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of {pc, instr}, plus the held output.
  logic [18:0] mq [$];
  logic [7:0]  m_pc, m_opc;
  logic [10:0] m_oins;
  int          m_fet, m_stall;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = 8'h00;
    m_opc   = 8'h00;
    m_oins  = 11'h000;
    m_fet   = 0;
    m_stall = 0;
  endtask

  task automatic model_step();
    bit pop, push;
    pop  = (mq.size() != 0) && out_ready;
    push = !halt && !flush && ((mq.size() < 4) || pop);
    if (mq.size() != 0 && !out_ready && m_stall < 65535) m_stall++;
    if (push && m_fet < 65535) m_fet++;
    if (flush) begin
      mq.delete();
      m_pc = flush_pc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({m_pc, mem[m_pc]});
        m_pc = m_pc + 8'd1;
      end
    end
    if (mq.size() != 0) {m_opc, m_oins} = mq[0];
  endtask

  task automatic compare();
    check("mem_addr",  32'(mem_addr),  32'(m_pc));
    check("count",     32'(count),     32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("out_instr", 32'(out_instr), 32'(m_oins));
    check("out_pc",    32'(out_pc),    32'(m_opc));
`ifdef FETCH_QUEUE_STATS_EN
    check("stat_fetched", 32'(stat_fetched), 32'(m_fet));
    check("stat_stalls",  32'(stat_stalls),  32'(m_stall));
`endif
  endtask

  // One clock: compare at the negedge, advance model, step the DUT.
  task automatic cycle();
    compare();
    if (R) model_reset();
    else   model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] wrap_exp [4];
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
    for (int i = 0; i < 256; i++) mem[i] = (i < 8) ? 11'(i) : 11'(i * 7 + 3);

    R = 1'b1; halt = 1'b0; flush = 1'b0; out_ready = 1'b0; flush_pc = 8'h00;
    model_reset();
    @(negedge clk);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_count",     32'(count),     32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instr", 32'(out_instr), 32'h0);
    check("rst_out_pc",    32'(out_pc),    32'h0);
    cycle();

    // Streaming from address 0
    R = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("seq_instr", 32'(out_instr), 32'(k - 1));
      check("seq_pc",    32'(out_pc),    32'(k - 1));
    end

    // Back-pressure fills the queue, then push and pop at full
    flush = 1'b1; flush_pc = 8'h00; out_ready = 1'b0;
    cycle();
    flush = 1'b0;
    repeat (10) cycle();
    check("stall_count", 32'(count),     32'd4);
    check("stall_addr",  32'(mem_addr),  32'd4);
    check("stall_instr", 32'(out_instr), 32'd0);
    check("stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cycle();
    check("full_pp_count", 32'(count),     32'd4);
    check("full_pp_addr",  32'(mem_addr),  32'd5);
    check("full_pp_instr", 32'(out_instr), 32'd1);
    repeat (4) cycle();

    // Redirect mid-stream
    flush = 1'b1; flush_pc = 8'hF0;
    cycle();
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_count", 32'(count),     32'd0);
    check("flush_addr",  32'(mem_addr),  32'hF0);
    cycle();
    check("flush_pc0",    32'(out_pc),    32'hF0);
    check("flush_instr0", 32'(out_instr), 32'd1683);
    cycle();
    check("flush_pc1", 32'(out_pc), 32'hF1);

    flush = 1'b1; flush_pc = 8'hFE;
    cycle();
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("wrap_pc", 32'(out_pc), 32'(wrap_exp[k]));
    end

    // Halt drains queued entries then holds PC
    flush = 1'b1; flush_pc = 8'h10; out_ready = 1'b0;
    cycle();
    flush = 1'b0;
    repeat (3) cycle();
    check("halt_pre_count", 32'(count),    32'd3);
    check("halt_pre_addr",  32'(mem_addr), 32'h13);
    halt = 1'b1; out_ready = 1'b1;
    repeat (3) cycle();
    check("halt_count", 32'(count),     32'd0);
    check("halt_valid", 32'(out_valid), 32'd0);
    cycle();
    check("halt_addr",    32'(mem_addr), 32'h13);
    check("halt_hold_pc", 32'(out_pc),   32'h12);
    halt = 1'b0;
    cycle();
    check("resume_pc",    32'(out_pc),    32'h13);
    check("resume_valid", 32'(out_valid), 32'd1);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      halt      = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      flush_pc  = 8'($urandom);
      cycle();
    end

    // Asynchronous reset between edges with three entries queued
    halt = 1'b0; flush = 1'b1; flush_pc = 8'h40; out_ready = 1'b0;
    cycle();
    flush = 1'b0;
    repeat (3) cycle();
    check("arst_pre_count", 32'(count), 32'd3);
    #2;
    R = 1'b1;
    #1;
    check("arst_count", 32'(count),     32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_addr",  32'(mem_addr),  32'd0);
    check("arst_pc",    32'(out_pc),    32'd0);
`ifdef FETCH_QUEUE_STATS_EN
    check("arst_fetched", 32'(stat_fetched), 32'd0);
    check("arst_stalls",  32'(stat_stalls),  32'd0);
`endif
    model_reset();
    @(negedge clk);
    cycle();
    R = 1'b0;
    for (int n = 0; n < 200; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      halt      = ($urandom_range(0, 15) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      flush_pc  = 8'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
